// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared types and helpers for the round-robin BCD conversion arbiter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } bcd_state_e;

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  function automatic longint unsigned max_dec(input int digits);
    longint unsigned v;
    v = 1;
    for (int i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Requester-side bus of the BCD conversion arbiter.
//
// Handshake: a requester raises req_i[k] and holds req_i[k] and its operand
// in data_i[k*DATA_W +: DATA_W] stable until ack_o[k] pulses for exactly one
// cycle. bcd_o/id_o/ovf_o are valid in that cycle and hold until the next
// ack. A request may be withdrawn before it is granted; once granted it is
// ignored until its ack.
interface bcd_conv_arbiter_if
  import bcd_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 20,
  parameter int DIGITS = 6
) ();

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]             req_i;
  logic [N_REQ*DATA_W-1:0]      data_i;
  logic [N_REQ-1:0]             ack_o;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o;
  logic [ID_W-1:0]              id_o;
  logic                         ovf_o;
  logic                         busy_o;
  bcd_state_e                   state_o;

  modport master (
    output req_i, data_i,
    input  ack_o, bcd_o, id_o, ovf_o, busy_o, state_o
  );

  modport slave (
    input  req_i, data_i,
    output ack_o, bcd_o, id_o, ovf_o, busy_o, state_o
  );

endinterface

// File: rtl/bcd_conv_arbiter_dd_step.sv
// One double-dabble iteration: add 3 to every BCD digit above 4, then shift
// the whole {digits, operand} register left by one bit.
module bcd_dd_step
  import bcd_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int DIGITS = 6
) (
  input  logic [DIGITS*BCD_DIGIT_W+DATA_W-1:0] i_sr,
  output logic [DIGITS*BCD_DIGIT_W+DATA_W-1:0] o_sr
);

  localparam int SR_W = DIGITS*BCD_DIGIT_W + DATA_W;

  logic [SR_W-1:0] w_adj;

  // Digit correction followed by the single-bit shift.
  always_comb begin
    w_adj = i_sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (i_sr[DATA_W + d*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd4) begin
        w_adj[DATA_W + d*BCD_DIGIT_W +: BCD_DIGIT_W] =
          i_sr[DATA_W + d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
      end
    end
    o_sr = {w_adj[SR_W-2:0], 1'b0};
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one sequential double-dabble binary-to-BCD
// engine between N_REQ requesters.
// Optional build macro BCD_ARB_OVF_SAT_EN: when defined, an overflowing
// operand reports all-nines on bcd_o instead of the modulo result.
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 20,
  parameter int DIGITS = 6
) (
  input  logic              clk,
  input  logic              rst,
  bcd_conv_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int SUM_W = ID_W + 1;
  localparam int BCD_W = DIGITS * BCD_DIGIT_W;
  localparam int SR_W  = BCD_W + DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam longint unsigned MAX_DEC = max_dec(DIGITS);

  bcd_state_e       r_state, w_state_nxt;
  logic [ID_W-1:0]  r_ptr, r_id, r_id_out;
  logic [ID_W-1:0]  w_off, w_win, w_ptr_nxt;
  logic [SUM_W-1:0] w_sum;
  logic [N_REQ-1:0] w_mask, w_req_m, w_req_rot;
  logic [CNT_W-1:0] r_cnt;
  logic [SR_W-1:0]  r_sr, w_sr_step;
  logic [DATA_W-1:0] r_operand, w_operand;
  logic [N_REQ-1:0] r_ack;
  logic [BCD_W-1:0] r_bcd, w_bcd_res;
  logic             r_ovf, w_ovf;
  logic             w_found, w_grant, w_step, w_finish;

  bcd_dd_step #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_step (
    .i_sr (r_sr),
    .o_sr (w_sr_step)
  );

  // Round-robin pick: rotate requests so the pointer is bit 0, take the
  // first set bit, rotate back. The requester just served is masked while
  // its ack is on the bus so it cannot be re-granted on the closing edge.
  always_comb begin
    w_mask = '0;
    if (r_state == S_DONE) begin
      w_mask = N_REQ'(1) << r_id;
    end
    w_req_m   = bus.req_i & ~w_mask;
    w_req_rot = N_REQ'({w_req_m, w_req_m} >> r_ptr);
    w_found   = 1'b0;
    w_off     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_found = 1'b1;
        w_off   = ID_W'(i);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= SUM_W'(N_REQ)) begin
      w_sum = w_sum - SUM_W'(N_REQ);
    end
    w_win     = w_sum[ID_W-1:0];
    w_ptr_nxt = (w_win == ID_W'(N_REQ-1)) ? '0 : w_win + 1'b1;
  end

  // Operand mux for the winning requester.
  always_comb begin
    w_operand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_operand = bus.data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Overflow is judged on the latched operand; the digit field already
  // holds operand mod 10^DIGITS because carries out of the top digit drop.
  assign w_ovf = (64'(r_operand) > MAX_DEC);
`ifdef BCD_ARB_OVF_SAT_EN
  assign w_bcd_res = w_ovf ? {DIGITS{4'h9}} : r_sr[SR_W-1 -: BCD_W];
`else
  assign w_bcd_res = r_sr[SR_W-1 -: BCD_W];
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and datapath strobes. CONV spends DATA_W cycles shifting and
  // one more cycle (counter == DATA_W) registering the result.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        if (r_cnt == CNT_W'(DATA_W)) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      S_DONE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_CONV;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath, pointer, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_id_out  <= '0;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_operand <= '0;
      r_ack     <= '0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_ack <= '0;
      if (w_grant) begin
        r_operand <= w_operand;
        r_id      <= w_win;
        r_sr      <= {{BCD_W{1'b0}}, w_operand};
        r_cnt     <= '0;
        r_ptr     <= w_ptr_nxt;
      end
      if (w_step) begin
        r_sr  <= w_sr_step;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_finish) begin
        r_ack    <= N_REQ'(1) << r_id;
        r_bcd    <= w_bcd_res;
        r_id_out <= r_id;
        r_ovf    <= w_ovf;
      end
    end
  end

  assign bus.ack_o   = r_ack;
  assign bus.bcd_o   = r_bcd;
  assign bus.id_o    = r_id_out;
  assign bus.ovf_o   = r_ovf;
  assign bus.busy_o  = (r_state != S_IDLE);
  assign bus.state_o = r_state;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: directed cases plus randomized batches,
// checked against a decimal-arithmetic reference model and an expected queue.
module tb_bcd_conv_arbiter;
  import bcd_pkg::*;

  localparam int N_REQ      = 4;
  localparam int DATA_W     = 20;
  localparam int DIGITS     = 6;
  localparam int ID_W       = 2;
  localparam int BCD_W      = 4 * DIGITS;
  localparam int ENT_W      = ID_W + 1 + BCD_W;
  localparam int PERIOD     = DATA_W + 2;
  localparam int ACK_BUDGET = N_REQ * PERIOD + 2;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  int   m_ptr;
  logic [ENT_W-1:0] exp_q[$];

  bcd_conv_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .DIGITS(DIGITS)) bus ();

  bcd_conv_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded its time limit (total=%0d)", n_total);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: decimal digits of the value mod 10^DIGITS (or all nines when
  // saturation is built in and the value is out of range).
  function automatic logic [ENT_W-1:0] model_entry(input int k, input logic [DATA_W-1:0] v);
    int unsigned lim;
    int unsigned r;
    logic [BCD_W-1:0] b;
    logic ovf;
    lim = 1;
    for (int d = 0; d < DIGITS; d++) lim = lim * 10;
    ovf = (int'(v) > int'(lim - 1));
    r = v % lim;
`ifdef BCD_ARB_OVF_SAT_EN
    if (ovf) r = lim - 1;
`endif
    b = '0;
    for (int d = 0; d < DIGITS; d++) begin
      b[d*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return {ID_W'(k), ovf, b};
  endfunction

  // ---------------- driver tasks ----------------
  // Waits for the next ack; want_cyc is the number of falling edges expected
  // from the call to the ack (0 = not timed). Drops the acked request.
  task automatic expect_ack(input int want_cyc);
    int cyc;
    logic [ENT_W-1:0] e;
    logic [ID_W-1:0]  eid;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.ack_o == '0 && cyc <= ACK_BUDGET);
    if (bus.ack_o == '0) begin
      check("ack_timeout", 32'(cyc), 32'(want_cyc > 0 ? want_cyc : PERIOD));
      exp_q.delete();
      bus.req_i = '0;
      return;
    end
    if (exp_q.size() == 0) begin
      check("unexpected_ack", 32'(bus.ack_o), 32'(0));
      bus.req_i = bus.req_i & ~bus.ack_o;
      return;
    end
    e   = exp_q.pop_front();
    eid = e[ENT_W-1 -: ID_W];
    check("ack_onehot", 32'(bus.ack_o), 32'(1) << eid);
    check("id", 32'(bus.id_o), 32'(eid));
    check("bcd", 32'(bus.bcd_o), 32'(e[BCD_W-1:0]));
    check("ovf", 32'(bus.ovf_o), 32'(e[BCD_W]));
    if (want_cyc > 0) check("ack_timing", 32'(cyc), 32'(want_cyc));
    m_ptr = (int'(eid) + 1) % N_REQ;
    bus.req_i = bus.req_i & ~bus.ack_o;
  endtask

  // Raises every request in mask at once from an idle engine. Service order
  // is the wrap-around order starting after the last requester served; the
  // grant edge follows the raise, so each ack lands PERIOD falling edges
  // after the previous event.
  task automatic run_batch(input logic [N_REQ-1:0] mask, input logic [DATA_W-1:0] vals [N_REQ]);
    int k;
    int want;
    want = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (m_ptr + i) % N_REQ;
      if (mask[k]) begin
        exp_q.push_back(model_entry(k, vals[k]));
        want++;
      end
    end
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) bus.data_i[i*DATA_W +: DATA_W] = vals[i];
    bus.req_i = mask;
    for (int n = 0; n < want; n++) expect_ack(PERIOD);
    bus.req_i = '0;
    @(negedge clk);
    check("ack_pulse", 32'(bus.ack_o), 32'(0));
    check("busy_idle", 32'(bus.busy_o), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] vals [N_REQ];
    logic [DATA_W-1:0] bvals [4];
    logic [N_REQ-1:0]  mask;
    int acks;

    n_total = 0;
    n_bad   = 0;
    m_ptr   = 0;
    rst     = 1'b0;
    bus.req_i  = '0;
    bus.data_i = '0;
    bvals[0] = 20'd0;
    bvals[1] = 20'd999999;
    bvals[2] = 20'd1000000;
    bvals[3] = 20'd1048575;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus.ack_o), 32'(0));
    check("rst_bcd", 32'(bus.bcd_o), 32'(0));
    check("rst_id", 32'(bus.id_o), 32'(0));
    check("rst_ovf", 32'(bus.ovf_o), 32'(0));
    check("rst_busy", 32'(bus.busy_o), 32'(0));
    check("rst_state", 32'(bus.state_o), 32'(S_IDLE));
    rst = 1'b1;
    @(negedge clk);

    // Single request, requester 0
    for (int i = 0; i < N_REQ; i++) vals[i] = DATA_W'($urandom_range(0, 1048575));
    vals[0] = 20'd123456;
    run_batch(4'b0001, vals);

    // Boundary operands on rotating requesters
    for (int b = 0; b < 4; b++) begin
      vals[(b + 1) % N_REQ] = bvals[b];
      run_batch(N_REQ'(1) << ((b + 1) % N_REQ), vals);
    end

    // All four held from the same cycle
    vals[0] = 20'd1; vals[1] = 20'd22; vals[2] = 20'd333; vals[3] = 20'd4444;
    run_batch(4'b1111, vals);

    // Pointer rotation: serve 2, then 0 and 2 together
    vals[0] = 20'd8642; vals[2] = 20'd97531;
    run_batch(4'b0100, vals);
    run_batch(4'b0101, vals);

    // Reset ten cycles into a conversion
    @(negedge clk);
    bus.data_i[3*DATA_W +: DATA_W] = 20'd777777;
    bus.req_i = 4'b1000;
    repeat (11) @(negedge clk);
    check("busy_conv", 32'(bus.busy_o), 32'(1));
    check("state_conv", 32'(bus.state_o), 32'(S_CONV));
    #2 rst = 1'b0;
    #1;
    check("abort_ack", 32'(bus.ack_o), 32'(0));
    check("abort_bcd", 32'(bus.bcd_o), 32'(0));
    check("abort_id", 32'(bus.id_o), 32'(0));
    check("abort_ovf", 32'(bus.ovf_o), 32'(0));
    check("abort_busy", 32'(bus.busy_o), 32'(0));
    bus.req_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    acks = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ack_o != '0) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'(0));
    m_ptr = 0;
    vals[3] = 20'd777777;
    run_batch(4'b1000, vals);

    // Withdrawal: requester 1 gives up while requester 0 converts
    exp_q.push_back(model_entry(0, 20'd31415));
    @(negedge clk);
    bus.data_i[0 +: DATA_W]      = 20'd31415;
    bus.data_i[DATA_W +: DATA_W] = 20'd27182;
    bus.req_i = 4'b0011;
    repeat (10) @(negedge clk);
    check("busy_wd", 32'(bus.busy_o), 32'(1));
    bus.req_i[1] = 1'b0;
    expect_ack(PERIOD - 10);
    bus.req_i = '0;
    @(negedge clk);
    check("wd_busy_idle", 32'(bus.busy_o), 32'(0));
    acks = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ack_o != '0) acks++;
    end
    check("wd_no_ack", 32'(acks), 32'(0));

    // Randomized batches
    for (int t = 0; t < 16; t++) begin
      mask = N_REQ'($urandom_range(1, 15));
      for (int i = 0; i < N_REQ; i++) begin
        case ($urandom_range(0, 3))
          0:       vals[i] = DATA_W'($urandom_range(0, 999999));
          1:       vals[i] = DATA_W'($urandom_range(1000000, 1048575));
          2:       vals[i] = bvals[$urandom_range(0, 3)];
          default: vals[i] = DATA_W'($urandom_range(0, 99));
        endcase
      end
      run_batch(mask, vals);
    end

    // Final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
Shares one sequential double-dabble binary-to-BCD engine between N_REQ requesters. It uses round-robin arbitration and a req/ack handshake.
Each requester presents a 20-bit binary value and receives a 6-digit packed BCD result, a requester ID and an overflow flag.
The block sits between measurement/counter sources and the seven-segment display drivers.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 20, binary input width; also the number of conversion iterations
DIGITS, 6, BCD output digits (result width 4*DIGITS)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req_i  in  N_REQ  per-requester conversion request, level
data_i  in  N_REQ*DATA_W  packed operands; requester k uses bits [k*DATA_W +: DATA_W]
ack_o  out  N_REQ  one-cycle one-hot completion pulse
bcd_o  out  4*DIGITS  result; digit 0 (units) in [3:0], up to digit DIGITS-1
id_o  out  clog2(N_REQ)  index of the requester owning bcd_o
ovf_o  out  1  operand exceeded 10^DIGITS-1
busy_o  out  1  engine occupied (state != IDLE)

Behaviour:
- Reset (rst low, async) sets:
  - state IDLE
  - ack_o=0, bcd_o=0, id_o=0, ovf_o=0, busy_o=0
  - round-robin pointer to requester 0
  - iteration counter 0
- Reset mid-conversion aborts the conversion; no ack is issued.
- Handshake:
  - A requester raises req_i[k] and holds req_i[k] and its data stable until ack_o[k].
  - ack_o[k] is high for exactly one cycle. bcd_o, id_o and ovf_o are valid in that cycle and hold until the next ack.
  - A requester may drop req before it is granted. After grant, req is ignored until ack.
- Arbitration:
  - Round-robin. Search starts at pointer; the first asserted req wins.
  - On grant, pointer becomes winner+1 mod N_REQ.
- States:
  - IDLE: if any req, grant on this edge: latch operand and id, clear the shift register, counter=0, go to CONV.
  - CONV: each cycle, every 4-bit digit >4 gets +3, then the whole {digits,operand} register shifts left by 1. This is one combined step per cycle. Counter increments. After iteration DATA_W-1, go to DONE.
  - DONE: ack_o[id] high, outputs registered. On the closing edge, arbitrate again with the just-served requester masked for that edge. Grant (go to CONV) or go to IDLE.
- Latency:
  - Grant edge E0; edges E1..E_DATA_W perform the iterations; ack_o is high in the cycle after edge E_(DATA_W+1).
  - That is 21 cycles from the grant edge for DATA_W=20.
  - Back-to-back throughput is one conversion per DATA_W+2 cycles.
- Overflow:
  - ovf_o = (operand > 10^DIGITS-1), evaluated on the latched operand.
  - Without the optional feature, bcd_o = operand mod 10^DIGITS.
- Simultaneous requests: only one grant per arbitration edge. The others wait; none is dropped.
- Starvation bound: any held request is acked within N_REQ*(DATA_W+2)+1 cycles.

Optional Feature:
- Macro: BCD_ARB_OVF_SAT_EN.
- Defined: when ovf_o=1, bcd_o is forced to all digits 9 (24'h999999 for defaults). ovf_o still asserts.
- Undefined: bcd_o is the modulo result as above; ovf_o asserts.

Decomposition:
- Package bcd_pkg:
  - localparam BCD_DIGIT_W=4
  - state enum IDLE/CONV/DONE as localparams
  - function max_dec(DIGITS) returning 10^DIGITS-1
- One sub-module, bcd_dd_step: combinational add-3 plus shift-left of the {DIGITS*4+DATA_W} register.
- The FSM, arbiter and counter stay in bcd_conv_arbiter.

Test Plan:
- Single request: req_i=4'b0001, data 123456 -> ack_o=4'b0001 exactly 21 cycles after the grant edge; bcd_o=24'h123456, id_o=0, ovf_o=0.
- Boundary values:
  - 0 -> 24'h000000
  - 999999 -> 24'h999999, ovf_o=0
  - 1000000 -> ovf_o=1 with bcd_o 24'h000000 (macro off) or 24'h999999 (macro on)
  - 1048575 -> ovf_o=1 with bcd_o 24'h048575 (macro off) or 24'h999999 (macro on)
- All four requesters held high from the same cycle, with data 1, 22, 333, 4444 -> acks in order 0,1,2,3; each 22 cycles apart; results 24'h000001, 24'h000022, 24'h000333, 24'h004444.
- Pointer rotation: requester 2 served, then req_i=4'b0101 -> requester 0 (next after 2 in wrap order: 3,0) is granted before requester 2.
- Reset mid-operation: assert rst low 10 cycles into CONV -> all outputs 0 immediately; no ack; after release, a new request converts correctly.
- Withdrawal: requester 1 drops req before grant while requester 0 is in conversion -> requester 1 never acked; busy_o returns to 0 after requester 0's ack.
